// File: rtl/cmp_pkg.sv
// Shared types for the comparator result path.
// Relation encoding and run-counter width.
package cmp_pkg;

  typedef enum logic [1:0] {
    CMP_EQ = 2'b00,
    CMP_GT = 2'b01,
    CMP_LT = 2'b10
  } cmp_rel_t;

  localparam int CMP_RUN_W = 8;

  // {gt, lt, eq}
  function automatic logic [2:0] rel_onehot(cmp_rel_t r);
    logic [2:0] o;
    o = 3'b001;
    unique case (1'b1)
      (r == CMP_GT): o = 3'b100;
      (r == CMP_LT): o = 3'b010;
      default:       o = 3'b001;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/cmp_result_filter_sat_counter.sv
// Saturating up-counter for committed transitions.
// clr has priority over inc; holds at all-ones.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (inc && (q != {W{1'b1}})) begin
      q <= q + 1'b1;
    end
  end

endmodule

// File: rtl/cmp_result_filter.sv
// Debounce filter on comparator agb/alb/aeb flags.
// CMP_FILTER_ERR_EN: enables illegal-sample detection and onehot_err.
module cmp_result_filter
  import cmp_pkg::*;
#(
  parameter int DEBOUNCE = 4,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic             agb,
  input  logic             alb,
  input  logic             aeb,
  input  logic             clr,
  output logic             f_gt,
  output logic             f_lt,
  output logic             f_eq,
  output logic             change,
  output logic [CNT_W-1:0] gt_cnt,
  output logic [CNT_W-1:0] lt_cnt,
  output logic [CNT_W-1:0] eq_cnt,
  output logic             onehot_err
);

  localparam cmp_rel_t S_EQ = CMP_EQ;
  localparam cmp_rel_t S_GT = CMP_GT;
  localparam cmp_rel_t S_LT = CMP_LT;

  localparam logic [CMP_RUN_W-1:0] RUN_ONE = CMP_RUN_W'(1);
  localparam logic [CMP_RUN_W-1:0] RUN_END = CMP_RUN_W'(DEBOUNCE);

  cmp_rel_t             state_q, state_n;
  cmp_rel_t             cand_q, cand_n;
  cmp_rel_t             samp;
  logic [CMP_RUN_W-1:0] run_q, run_n;
  logic                 legal;
  logic                 commit;

  always_comb begin
    samp = agb ? S_GT : (alb ? S_LT : S_EQ);
`ifdef CMP_FILTER_ERR_EN
    legal = $onehot({agb, alb, aeb});
`else
    legal = 1'b1;
`endif
  end

  always_comb begin
    state_n = state_q;
    cand_n  = cand_q;
    run_n   = run_q;
    commit  = 1'b0;
    if (in_valid) begin
      if (!legal) begin
        run_n = '0;
      end else if (samp == state_q) begin
        run_n = '0;
      end else begin
        if (samp == cand_q) begin
          run_n = run_q + 1'b1;
        end else begin
          cand_n = samp;
          run_n  = RUN_ONE;
        end
        if (run_n == RUN_END) begin
          commit  = 1'b1;
          state_n = cand_n;
          run_n   = '0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_EQ;
      cand_q  <= CMP_EQ;
      run_q   <= '0;
      f_gt    <= 1'b0;
      f_lt    <= 1'b0;
      f_eq    <= 1'b1;
      change  <= 1'b0;
    end else begin
      state_q              <= state_n;
      cand_q               <= cand_n;
      run_q                <= run_n;
      {f_gt, f_lt, f_eq}   <= rel_onehot(state_n);
      change               <= commit;
    end
  end

  sat_counter #(.W(CNT_W)) u_gt_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .inc  (commit && (state_n == S_GT)),
    .clr  (clr),
    .q    (gt_cnt)
  );

  sat_counter #(.W(CNT_W)) u_lt_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .inc  (commit && (state_n == S_LT)),
    .clr  (clr),
    .q    (lt_cnt)
  );

  sat_counter #(.W(CNT_W)) u_eq_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .inc  (commit && (state_n == S_EQ)),
    .clr  (clr),
    .q    (eq_cnt)
  );

`ifdef CMP_FILTER_ERR_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      onehot_err <= 1'b0;
    end else if (clr) begin
      onehot_err <= 1'b0;
    end else if (in_valid && !legal) begin
      onehot_err <= 1'b1;
    end
  end
`else
  logic unused_aeb;
  assign unused_aeb = aeb;
  assign onehot_err = 1'b0;
`endif

endmodule

// File: tb/tb_cmp_result_filter.sv
// Scoreboard bench for cmp_result_filter (DEBOUNCE=4, CNT_W=2).
module tb_cmp_result_filter;
  import cmp_pkg::*;

  localparam int DEB = 4;
  localparam int CW  = 2;
  localparam int CMAX = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          agb = 1'b0, alb = 1'b0, aeb = 1'b0;
  logic          clr = 1'b0;
  logic          f_gt, f_lt, f_eq, change, onehot_err;
  logic [CW-1:0] gt_cnt, lt_cnt, eq_cnt;

  int vectors = 0;
  int miscompares = 0;

  typedef struct packed {
    logic [2:0]    f;
    logic          chg;
    logic [CW-1:0] gt;
    logic [CW-1:0] lt;
    logic [CW-1:0] eq;
    logic          err;
  } exp_t;

  exp_t exp_q[$];

  cmp_rel_t m_state, m_cand;
  int       m_run, m_gt, m_lt, m_eq;
  logic     m_err;

  always #5 clk = ~clk;

  cmp_result_filter #(.DEBOUNCE(DEB), .CNT_W(CW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .agb       (agb),
    .alb       (alb),
    .aeb       (aeb),
    .clr       (clr),
    .f_gt      (f_gt),
    .f_lt      (f_lt),
    .f_eq      (f_eq),
    .change    (change),
    .gt_cnt    (gt_cnt),
    .lt_cnt    (lt_cnt),
    .eq_cnt    (eq_cnt),
    .onehot_err(onehot_err)
  );

  task automatic check(string tag, logic [31:0] obs, logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    m_state = CMP_EQ;
    m_cand  = CMP_EQ;
    m_run   = 0;
    m_gt = 0; m_lt = 0; m_eq = 0;
    m_err = 1'b0;
  endtask

  function automatic logic [2:0] exp_f(cmp_rel_t r);
    if (r == CMP_GT) return 3'b100;
    if (r == CMP_LT) return 3'b010;
    return 3'b001;
  endfunction

  task automatic step(logic v, logic a, logic l, logic e, logic c);
    exp_t     x;
    cmp_rel_t s;
    logic     lg;
    logic     chg;
    exp_t     got;
    @(negedge clk);
    in_valid = v; agb = a; alb = l; aeb = e; clr = c;
    chg = 1'b0;
    if (v) begin
`ifdef CMP_FILTER_ERR_EN
      lg = (int'(a) + int'(l) + int'(e)) == 1;
`else
      lg = 1'b1;
`endif
      s = a ? CMP_GT : (l ? CMP_LT : CMP_EQ);
      if (!lg) begin
        m_run = 0;
        m_err = 1'b1;
      end else if (s == m_state) begin
        m_run = 0;
      end else begin
        if (s == m_cand) m_run = m_run + 1;
        else begin
          m_cand = s;
          m_run = 1;
        end
        if (m_run == DEB) begin
          m_state = m_cand;
          m_run = 0;
          chg = 1'b1;
          if (s == CMP_GT && m_gt < CMAX) m_gt++;
          if (s == CMP_LT && m_lt < CMAX) m_lt++;
          if (s == CMP_EQ && m_eq < CMAX) m_eq++;
        end
      end
    end
    if (c) begin
      m_gt = 0; m_lt = 0; m_eq = 0;
      m_err = 1'b0;
    end
    x.f   = exp_f(m_state);
    x.chg = chg;
    x.gt  = CW'(m_gt);
    x.lt  = CW'(m_lt);
    x.eq  = CW'(m_eq);
    x.err = m_err;
    exp_q.push_back(x);
    @(posedge clk);
    #1;
    x = exp_q.pop_front();
    got = '{f: {f_gt, f_lt, f_eq}, chg: change, gt: gt_cnt,
            lt: lt_cnt, eq: eq_cnt, err: onehot_err};
    check("step_outputs", 32'(got), 32'(x));
  endtask

  task automatic rep(int n, logic v, logic a, logic l, logic e);
    for (int i = 0; i < n; i++) step(v, a, l, e, 1'b0);
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    check("reset_f", 32'({f_gt, f_lt, f_eq}), 32'(3'b001));
    check("reset_cnt", 32'({gt_cnt, lt_cnt, eq_cnt}), 32'h0);
    rst_n = 1'b1;

    // idle after reset
    rep(5, 1'b0, 1'b0, 1'b0, 1'b0);
    check("idle_eq", 32'(f_eq), 32'h1);
    check("idle_err", 32'(onehot_err), 32'h0);

    // four agb samples commit on the 4th edge
    rep(3, 1'b1, 1'b1, 1'b0, 1'b0);
    check("gt_no_early", 32'(change), 32'h0);
    rep(1, 1'b1, 1'b1, 1'b0, 1'b0);
    check("gt_change", 32'(change), 32'h1);
    check("gt_f", 32'(f_gt), 32'h1);
    check("gt_cnt1", 32'(gt_cnt), 32'h1);
    rep(1, 1'b1, 1'b1, 1'b0, 1'b0);
    check("gt_5th_nopulse", 32'(change), 32'h0);

    // back to EQ, then a glitch breaks the run
    rep(4, 1'b1, 1'b0, 1'b0, 1'b1);
    check("eq_back", 32'(f_eq), 32'h1);
    rep(3, 1'b1, 1'b1, 1'b0, 1'b0);
    rep(1, 1'b1, 1'b0, 1'b1, 1'b0);
    rep(3, 1'b1, 1'b1, 1'b0, 1'b0);
    check("glitch_hold_eq", 32'(f_eq), 32'h1);
    rep(1, 1'b1, 1'b1, 1'b0, 1'b0);
    check("glitch_commit_gt", 32'({f_gt, change}), 32'h3);
    check("gt_cnt2", 32'(gt_cnt), 32'h2);

    // gap in valid does not break a run
    rep(2, 1'b1, 1'b0, 1'b1, 1'b0);
    rep(10, 1'b0, 1'b0, 1'b1, 1'b0);
    check("gap_hold_gt", 32'(f_gt), 32'h1);
    rep(2, 1'b1, 1'b0, 1'b1, 1'b0);
    check("gap_commit_lt", 32'({f_lt, change}), 32'h3);
    check("lt_cnt1", 32'(lt_cnt), 32'h1);

    // non-one-hot sample in the middle of a GT run
    rep(3, 1'b1, 1'b1, 1'b0, 1'b0);
    rep(1, 1'b1, 1'b1, 1'b1, 1'b0);
`ifdef CMP_FILTER_ERR_EN
    check("err_set", 32'(onehot_err), 32'h1);
    check("err_no_commit", 32'(f_lt), 32'h1);
`else
    check("err_tied", 32'(onehot_err), 32'h0);
    check("prio_commit_gt", 32'(f_gt), 32'h1);
`endif
    rep(1, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("clr_err", 32'(onehot_err), 32'h0);
    check("clr_cnt", 32'({gt_cnt, lt_cnt, eq_cnt}), 32'h0);

    // alternate EQ/GT commits to saturate 2-bit counters
    for (int k = 0; k < 5; k++) begin
      rep(4, 1'b1, 1'b0, 1'b0, 1'b1);
      rep(4, 1'b1, 1'b1, 1'b0, 1'b0);
    end
    check("sat_gt", 32'(gt_cnt), 32'h3);
    check("sat_eq", 32'(eq_cnt), 32'h3);

    // clr coincident with a commit: state commits, counters clear
    rep(3, 1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    check("clr_commit_f", 32'({f_lt, change}), 32'h3);
    check("clr_commit_cnt", 32'(lt_cnt), 32'h0);

    // build counts then async reset mid-run
    rep(4, 1'b1, 1'b1, 1'b0, 1'b0);
    rep(2, 1'b1, 1'b0, 1'b0, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("async_f", 32'({f_gt, f_lt, f_eq}), 32'(3'b001));
    check("async_cnt", 32'({gt_cnt, lt_cnt, eq_cnt}), 32'h0);
    check("async_chg", 32'(change), 32'h0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    rep(3, 1'b1, 1'b1, 1'b0, 1'b0);
    rep(1, 1'b1, 1'b1, 1'b0, 1'b0);
    check("post_reset_gt", 32'(gt_cnt), 32'h1);
    check("sb_empty", 32'(exp_q.size()), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/cmp_result_filter.md
# cmp_result_filter

Debounce and event-tracking stage downstream of the magnitude comparator. It consumes the comparator's one-hot agb/alb/aeb flags each valid cycle and commits a new filtered relation only after DEBOUNCE consecutive identical samples. It emits a single-cycle change pulse on each commit and keeps saturating counts of committed transitions per relation. Sits between the comparator and the threshold/alarm logic, which must not react to single-sample glitches on a noisy operand.

## Interface
- DEBOUNCE, 4: consecutive identical valid samples required to commit; legal range 1..255
- CNT_W, 16: width of each transition counter
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  agb/alb/aeb carry a sample this cycle
- agb  in  1  comparator a>b
- alb  in  1  comparator a<b
- aeb  in  1  comparator a==b
- clr  in  1  synchronous clear of counters and error flag
- f_gt  out  1  filtered a>b
- f_lt  out  1  filtered a<b
- f_eq  out  1  filtered a==b
- change  out  1  one-cycle pulse on each commit
- gt_cnt  out  CNT_W  committed transitions into GT, saturating
- lt_cnt  out  CNT_W  committed transitions into LT, saturating
- eq_cnt  out  CNT_W  committed transitions into EQ, saturating
- onehot_err  out  1  sticky: a valid sample was not one-hot

## Operation
- FSM on filtered relation: S_EQ, S_GT, S_LT; f_* is the one-hot decode of the state, always registered.
- Candidate register cand (relation) plus run counter run (8 bits).
- Valid, legal sample equal to current state: run cleared to 0.
- Valid, legal sample differing from state and equal to cand: run increments.
- Valid, legal sample differing from state and cand: cand loads the sample, run set to 1.
- Commit when the updated run reaches DEBOUNCE: state changes to cand, run cleared, change asserted, counter for the new state increments unless all-ones.
- in_valid low: state, cand and run hold. A gap does not break a run.
- Illegal sample (valid, not exactly one bit set): run cleared, no commit.
- clr: gt_cnt, lt_cnt, eq_cnt and onehot_err go to 0. State, cand and run are unaffected. If a commit happens in the same cycle, clr wins for the counters (all 0) and the state still commits with change asserted.

## Timing
- Reset values: state S_EQ (f_eq=1, f_gt=0, f_lt=0), cand=EQ, run=0, change=0, all counters 0, onehot_err=0.
- Latency: the f_* update and the change pulse are visible after the clock edge that samples the DEBOUNCE-th consecutive differing valid sample. With DEBOUNCE=1, this is the edge that samples the first differing sample.
- change is high exactly one cycle per commit. Back-to-back commits are possible only with DEBOUNCE=1.
- Counters update on the commit edge. At all-ones they hold.
- Reset asserted mid-run discards the candidate and returns all outputs to their reset values immediately (asynchronously).

## Configuration
- CMP_FILTER_ERR_EN defined: illegal samples are detected as described; onehot_err is sticky until clr or reset.
- CMP_FILTER_ERR_EN undefined: onehot_err is tied 0. Samples are priority-decoded: agb gives GT, else alb gives LT, else EQ. No sample is illegal.

## Structure
- Shared package cmp_pkg holds:
  - typedef cmp_rel_t, a 2-bit enum: CMP_EQ=2'b00, CMP_GT=2'b01, CMP_LT=2'b10.
  - Constant CMP_RUN_W=8.
- Sub-module sat_counter (parameter W; inputs clk, rst_n, inc, clr; output q; saturating; clr has priority over inc). It is instantiated three times for gt_cnt, lt_cnt and eq_cnt.

## Test plan
- Reset, then idle 5 cycles -> f_eq=1, change=0, all counters 0, onehot_err=0.
- DEBOUNCE=4, agb valid for 4 cycles -> change pulses once on the 4th edge, f_gt=1, gt_cnt=1. A 5th identical sample -> no pulse.
- DEBOUNCE=4, agb×3, one alb, agb×3 -> no commit, f_eq stays 1. A further agb -> commit to GT.
- DEBOUNCE=4, alb×2, in_valid low 10 cycles, alb×2 -> commit to LT on the 4th valid sample, lt_cnt=1.
- With ERR_EN: sample agb=alb=1 valid -> onehot_err=1, run cleared. clr -> onehot_err=0, counters 0, f_* unchanged.
- CNT_W=2, alternate GT/EQ commits 5 times each -> gt_cnt=3 and eq_cnt=3 (saturated). Reset asserted mid-run -> f_eq=1 and counters 0 immediately.
